// File: rtl/mask_scan_ctrl.sv
// Masked channel scan sequencer. An accepted start latches one mask from a
// small programmable table, then samples only the enabled channels, one per
// clock in ascending order, into a result vector and a hit count.
module mask_scan_ctrl #(
  parameter int N_CH      = 8,
  parameter int IDX_W     = 3,
  parameter int TBL_DEPTH = 8,
  parameter int TBL_AW    = 3,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TBL_AW-1:0] cfg_addr,
  input  logic              cfg_we,
  input  logic [TBL_AW-1:0] cfg_waddr,
  input  logic [N_CH-1:0]   cfg_wdata,
  input  logic [N_CH-1:0]   ch_in,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  cur_ch,
  output logic [N_CH-1:0]   result,
  output logic [CNT_W-1:0]  hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [TBL_DEPTH-1:0][N_CH-1:0] tbl;
  logic [N_CH-1:0]                mask_q;
  logic [N_CH-1:0]                eff_mask;
  logic                           start_hit, next_hit;
  logic [IDX_W-1:0]               start_ch, next_ch;
  logic [IDX_W:0]                 scan_from;

  // Lowest set bit of m at index >= lo; MSB of the return flags "found".
  function automatic logic [IDX_W:0] first_set(input logic [N_CH-1:0] m,
                                               input logic [IDX_W:0]  lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && (i >= int'(lo))) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  // A write to the entry being started wins, so software can retarget a scan
  // in the same cycle it launches it.
  assign eff_mask  = (cfg_we && (cfg_waddr == cfg_addr)) ? cfg_wdata : tbl[cfg_addr];
  assign scan_from = {1'b0, cur_ch} + {{IDX_W{1'b0}}, 1'b1};
  assign {start_hit, start_ch} = first_set(eff_mask, '0);
  assign {next_hit, next_ch}   = first_set(mask_q, scan_from);

  // Mask table: thermometer defaults on reset, writable in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TBL_DEPTH; i++)
        for (int j = 0; j < N_CH; j++)
          tbl[i][j] <= (j <= i);
    end else if (cfg_we) begin
      tbl[cfg_waddr] <= cfg_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; start outside IDLE is simply dropped.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = start_hit ? SCAN : DONE;
      SCAN: begin
        busy = 1'b1;
        if (!next_hit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: latch mask on start, then sample one enabled channel per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      cur_ch    <= '0;
      result    <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mask_q    <= eff_mask;
          result    <= '0;
          hit_count <= '0;
          if (start_hit) cur_ch <= start_ch;
        end
        SCAN: begin
          result[cur_ch] <= ch_in[cur_ch];
          hit_count      <= hit_count + CNT_W'(ch_in[cur_ch]);
          if (next_hit) cur_ch <= next_ch;
        end
        default: ;
      endcase
    end
  end

endmodule
